// File: rtl/wbm_cmd_master.sv
// Wishbone classic single-cycle master fed by a valid/ready command port and
// returning results on a valid/ready response port. Define WBM_TIMEOUT_EN to build the bus-timeout abort.
module wbm_cmd_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_we_i,
   input  logic [31:0] cmd_adr_i,
   input  logic [31:0] cmd_dat_i,
   input  logic [3:0]  cmd_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   // state | meaning
   // IDLE  | ready for a command, no bus cycle
   // BUS   | cyc/stb asserted, waiting for ack (or timeout)
   // RESP  | response held until consumer takes it
   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

   state_t state_q, state_d;
   logic   accept;
   logic   bus_done;
   logic   timeout;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   assign accept   = (state_q == IDLE) && cmd_valid_i;
   assign bus_done = (state_q == BUS) && (wbm_ack_i || timeout);

`ifdef WBM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] to_cnt_q;
   logic          rsp_err_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         to_cnt_q <= '0;
      end else if (accept) begin
         to_cnt_q <= '0;
      end else if (state_q == BUS && !wbm_ack_i) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   // Ack at the terminal edge still counts as success.
   assign timeout = (state_q == BUS) && !wbm_ack_i && (to_cnt_q == TO_LAST);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rsp_err_q <= 1'b0;
      end else if (bus_done) begin
         rsp_err_q <= !wbm_ack_i;
      end
   end

   assign rsp_err_o = rsp_err_q;
`else
   assign timeout   = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_valid_i) state_d = BUS;
         BUS:     if (wbm_ack_i || timeout) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Held low during reset so nothing is accepted before release.
   always_comb begin
      cmd_ready_o = (state_q == IDLE) && wb_rst_ni;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_adr_o   <= '0;
         wbm_dat_o   <= '0;
         wbm_sel_o   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
      end else begin
         if (accept) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
         end
         if (bus_done) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'h0;
         end
         if (state_q == RESP && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Randomized self-checking bench for wbm_cmd_master; expected bus pulse length and
// response are derived per transaction from the ack delay. Honors WBM_TIMEOUT_EN.
module tb_wbm_cmd_master;

   localparam int TO = 4;
`ifdef WBM_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [31:0] cmd_adr_i = '0;
   logic [31:0] cmd_dat_i = '0;
   logic [3:0]  cmd_sel_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_ack_i = 1'b0;
   logic [31:0] wbm_dat_i = '0;

   int n_tests = 0;
   int n_fail  = 0;

   wbm_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   // One transaction; ack_dly = BUS cycle index in which the slave raises ack.
   task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_dly, input logic [31:0] rdata,
                         input int hold, input bit stray_ack);
      int      n_stb;
      int      exp_n;
      bit      exp_err;
      logic [31:0] exp_dat;
      logic [31:0] held_dat;

      exp_err = TO_EN && (ack_dly >= TO);
      exp_n   = exp_err ? TO : ack_dly + 1;
      exp_dat = (exp_err || we) ? 32'h0 : rdata;

      check_eq("cmd_ready_idle", {31'b0, cmd_ready_o}, 32'd1);
      cmd_valid_i = 1'b1;
      cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
      rsp_ready_i = 1'b0;
      step();
      cmd_valid_i = 1'b0;
      cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = 4'($urandom);
      check_eq("bus_ctrl", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, {29'b0, 1'b1, 1'b1, we});
      check_eq("bus_adr", wbm_adr_o, adr);
      check_eq("bus_dat", wbm_dat_o, dat);
      check_eq("bus_sel", {28'b0, wbm_sel_o}, {28'b0, sel});

      n_stb = 0;
      for (int k = 0; k < ack_dly + TO + 10; k++) begin
         if (!wbm_stb_o) break;
         check_eq("busy_flags", {30'b0, cmd_ready_o, rsp_valid_o}, 32'd0);
         check_eq("bus_adr_hold", wbm_adr_o, adr);
         n_stb++;
         wbm_ack_i = (k == ack_dly);
         wbm_dat_i = (k == ack_dly) ? rdata : $urandom;
         step();
         wbm_ack_i = 1'b0;
      end
      check_eq("stb_cycles", n_stb, exp_n);
      check_eq("bus_idle", {30'b0, wbm_cyc_o, wbm_we_o}, 32'd0);
      check_eq("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
      check_eq("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
      check_eq("rsp_dat", rsp_dat_o, exp_dat);
      check_eq("adr_kept", wbm_adr_o, adr);

      held_dat = rsp_dat_o;
      for (int h = 0; h < hold; h++) begin
         wbm_ack_i = stray_ack && (h == hold / 2);
         wbm_dat_i = $urandom;
         step();
         wbm_ack_i = 1'b0;
         check_eq("bp_hold", {29'b0, rsp_valid_o, cmd_ready_o, wbm_stb_o}, {29'b0, 3'b100});
         check_eq("bp_dat", rsp_dat_o, held_dat);
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      check_eq("rsp_taken", {30'b0, rsp_valid_o, cmd_ready_o}, 32'd1);
   endtask

   initial begin
      #1;
      check_eq("rst_outs", {25'b0, cmd_ready_o, rsp_valid_o, rsp_err_o,
                            wbm_cyc_o, wbm_stb_o, wbm_we_o, |rsp_dat_o}, 32'd0);
      check_eq("rst_adr", wbm_adr_o | wbm_dat_o | {28'b0, wbm_sel_o}, 32'd0);
      #20;
      @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      #1;
      check_eq("ready_after_rst", {31'b0, cmd_ready_o}, 32'd1);
      step();

      // Directed: write with ack 2 cycles after stb, then read zero-wait back-to-back.
      do_txn(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 2, 32'hDEAD_BEEF, 0, 1'b0);
      do_txn(1'b0, 32'h3000_0000, 32'h0, 4'h3, 0, 32'h1234_5678, 0, 1'b0);
      do_txn(1'b0, 32'h3000_0008, 32'h0, 4'hC, 0, 32'h0BAD_F00D, 0, 1'b0);
      // Backpressure with a stray ack in RESP.
      do_txn(1'b0, 32'h3000_0010, 32'h0, 4'h1, 1, 32'hA5A5_5A5A, 10, 1'b1);
      if (TO_EN) begin
         do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 100, 32'h1111_2222, 0, 1'b0);
         do_txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, TO - 1, 32'h3333_4444, 0, 1'b0);
      end else begin
         do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1000, 32'h5555_6666, 0, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         do_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, TO + 2)), $urandom,
                int'($urandom_range(0, 3)), 1'($urandom));
      end

      // Reset in the middle of a bus cycle.
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0040;
      step();
      cmd_valid_i = 1'b0;
      check_eq("pre_rst_stb", {31'b0, wbm_stb_o}, 32'd1);
      #2;
      wb_rst_ni = 1'b0;
      #1;
      check_eq("rst_async_ctrl", {28'b0, wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, 32'd0);
      check_eq("rst_async_adr", wbm_adr_o, 32'h0);
      @(negedge wb_clk_i);
      wb_rst_ni = 1'b1;
      for (int c = 0; c < 4; c++) begin
         wbm_ack_i = (c == 1);
         step();
         wbm_ack_i = 1'b0;
         check_eq("post_rst", {29'b0, rsp_valid_o, cmd_ready_o, wbm_stb_o}, 32'd2);
      end
      do_txn(1'b0, 32'h3000_0044, 32'h0, 4'hF, 0, 32'h7777_8888, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
